// File: rtl/prbs_config_sequencer.sv
// prbs_config_sequencer
// Holds shadow copies of the PRBS generator configuration and applies them
// atomically: the generator is muted, given time to drain, loaded with all
// fields in one cycle, re-enabled, and then watched until it reports valid
// output (or a timeout expires).
module prbs_config_sequencer #(
    parameter int DRAIN_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int PN_COUNT       = 8
) (
    input  logic        dac_clk,
    input  logic        reset,
    input  logic        cfg_wr_en,
    input  logic [2:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    input  logic        commit_req,
    input  logic        prbs_valid,
    output logic        prbs_mode_select,
    output logic [4:0]  prbs_pn_select_reg,
    output logic [31:0] prbs_bit_rate_config_reg,
    output logic [7:0]  prbs_edge_time_config_reg,
    output logic [15:0] prbs_amplitude_config_reg,
    output logic [15:0] prbs_dc_offset_config_reg,
    output logic        busy,
    output logic        commit_done,
    output logic        cfg_err,
    output logic        timeout_err
);

    localparam int              TW           = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [7:0]      DRAIN_LAST   = 8'(DRAIN_CYCLES - 1);
    localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]     PN_LIMIT     = 32'(PN_COUNT);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        MUTE       = 3'd1,
        DRAIN      = 3'd2,
        LOAD       = 3'd3,
        ENABLE     = 3'd4,
        WAIT_VALID = 3'd5
    } state_t;

    state_t         state_r;
    state_t         state_n;

    // Shadow copies written by the host; only LOAD moves them to the outputs.
    logic [4:0]     sh_pn_r;
    logic [31:0]    sh_rate_r;
    logic [7:0]     sh_edge_r;
    logic [15:0]    sh_amp_r;
    logic [15:0]    sh_dc_r;
    logic           sh_en_r;

    logic           pending_r;
    logic [7:0]     drain_cnt_r;
    logic [TW-1:0]  tmo_cnt_r;

    logic           pending_n;
    logic [7:0]     drain_cnt_n;
    logic [TW-1:0]  tmo_cnt_n;
    logic           mode_n;
    logic           load_s;
    logic           done_n;
    logic           terr_n;
    logic           busy_n;

    // Shadow register writes and illegal-write flagging (accepted in any state).
    always_ff @(posedge dac_clk or posedge reset) begin
        if (reset) begin
            sh_pn_r   <= 5'd0;
            sh_rate_r <= 32'd0;
            sh_edge_r <= 8'd0;
            sh_amp_r  <= 16'd0;
            sh_dc_r   <= 16'd0;
            sh_en_r   <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            if (cfg_wr_en) begin
                case (cfg_addr)
                    3'd0: begin
                        // The full 32-bit value is range-checked so that large
                        // values cannot alias onto a legal PN after truncation.
                        if (cfg_wdata < PN_LIMIT) begin
                            sh_pn_r <= cfg_wdata[4:0];
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                    3'd1:    sh_rate_r <= cfg_wdata;
                    3'd2:    sh_edge_r <= cfg_wdata[7:0];
                    3'd3:    sh_amp_r  <= cfg_wdata[15:0];
                    3'd4:    sh_dc_r   <= cfg_wdata[15:0];
                    3'd5:    sh_en_r   <= cfg_wdata[0];
                    default: cfg_err   <= 1'b1;
                endcase
            end else begin
                cfg_err <= 1'b0;
            end
        end
    end

    // Commit sequencer state register.
    always_ff @(posedge dac_clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state decision for the commit sequence.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (commit_req || pending_r) state_n = MUTE;
                else                         state_n = IDLE;
            end
            MUTE: state_n = DRAIN;
            DRAIN: begin
                if (drain_cnt_r == DRAIN_LAST) state_n = LOAD;
                else                           state_n = DRAIN;
            end
            LOAD: state_n = ENABLE;
            ENABLE: begin
                if (sh_en_r) state_n = WAIT_VALID;
                else         state_n = IDLE;
            end
            WAIT_VALID: begin
                if (prbs_valid)                    state_n = IDLE;
                else if (tmo_cnt_r == TIMEOUT_LAST) state_n = IDLE;
                else                               state_n = WAIT_VALID;
            end
            default: state_n = IDLE;
        endcase
    end

    // Next values of counters, pending flag and registered status outputs.
    always_comb begin
        mode_n      = prbs_mode_select;
        drain_cnt_n = drain_cnt_r;
        tmo_cnt_n   = tmo_cnt_r;
        load_s      = 1'b0;
        done_n      = 1'b0;
        terr_n      = timeout_err;

        // Requests arriving while a sequence runs collapse into one rerun.
        if (state_r == IDLE)  pending_n = 1'b0;
        else if (commit_req)  pending_n = 1'b1;
        else                  pending_n = pending_r;

        case (state_r)
            IDLE: begin
                mode_n = prbs_mode_select;
            end
            MUTE: begin
                mode_n      = 1'b0;
                drain_cnt_n = 8'd0;
            end
            DRAIN: begin
                if (drain_cnt_r != DRAIN_LAST) drain_cnt_n = drain_cnt_r + 8'd1;
                else                           drain_cnt_n = drain_cnt_r;
            end
            LOAD: begin
                load_s = 1'b1;
            end
            ENABLE: begin
                if (sh_en_r) begin
                    mode_n    = 1'b1;
                    tmo_cnt_n = {TW{1'b0}};
                end else begin
                    // Disabled config: load is complete, generator stays muted.
                    done_n = 1'b1;
                    terr_n = 1'b0;
                end
            end
            WAIT_VALID: begin
                // prbs_valid is checked first so it wins over a same-cycle timeout.
                if (prbs_valid) begin
                    done_n = 1'b1;
                    terr_n = 1'b0;
                end else if (tmo_cnt_r == TIMEOUT_LAST) begin
                    mode_n = 1'b0;
                    terr_n = 1'b1;
                end else begin
                    tmo_cnt_n = tmo_cnt_r + TW'(1);
                end
            end
            default: begin
                mode_n = 1'b0;
            end
        endcase

        // Busy also covers the single IDLE cycle spent before a pending rerun.
        busy_n = (state_n != IDLE) || pending_n;
    end

    // Registered outputs, counters and the atomic config load.
    always_ff @(posedge dac_clk or posedge reset) begin
        if (reset) begin
            pending_r                 <= 1'b0;
            drain_cnt_r               <= 8'd0;
            tmo_cnt_r                 <= {TW{1'b0}};
            prbs_mode_select          <= 1'b0;
            prbs_pn_select_reg        <= 5'd0;
            prbs_bit_rate_config_reg  <= 32'd0;
            prbs_edge_time_config_reg <= 8'd0;
            prbs_amplitude_config_reg <= 16'd0;
            prbs_dc_offset_config_reg <= 16'd0;
            busy                      <= 1'b0;
            commit_done               <= 1'b0;
            timeout_err               <= 1'b0;
        end else begin
            pending_r        <= pending_n;
            drain_cnt_r      <= drain_cnt_n;
            tmo_cnt_r        <= tmo_cnt_n;
            prbs_mode_select <= mode_n;
            busy             <= busy_n;
            commit_done      <= done_n;
            timeout_err      <= terr_n;
            if (load_s) begin
                prbs_pn_select_reg        <= sh_pn_r;
                prbs_bit_rate_config_reg  <= sh_rate_r;
                prbs_edge_time_config_reg <= sh_edge_r;
                prbs_amplitude_config_reg <= sh_amp_r;
                prbs_dc_offset_config_reg <= sh_dc_r;
            end else begin
                prbs_pn_select_reg        <= prbs_pn_select_reg;
                prbs_bit_rate_config_reg  <= prbs_bit_rate_config_reg;
                prbs_edge_time_config_reg <= prbs_edge_time_config_reg;
                prbs_amplitude_config_reg <= prbs_amplitude_config_reg;
                prbs_dc_offset_config_reg <= prbs_dc_offset_config_reg;
            end
        end
    end

endmodule

// File: tb/tb_prbs_config_sequencer.sv
// Bench for prbs_config_sequencer: a timeline model (cycles since commit
// start) predicts every output each cycle; directed tests add hand-computed
// literal expectations for latencies and final register values.
module tb_prbs_config_sequencer;

    localparam int D  = 16;
    localparam int T  = 1024;
    localparam int PN = 8;

    logic        dac_clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_wr_en = 1'b0;
    logic [2:0]  cfg_addr = 3'd0;
    logic [31:0] cfg_wdata = 32'd0;
    logic        commit_req = 1'b0;
    logic        prbs_valid = 1'b0;
    logic        prbs_mode_select;
    logic [4:0]  prbs_pn_select_reg;
    logic [31:0] prbs_bit_rate_config_reg;
    logic [7:0]  prbs_edge_time_config_reg;
    logic [15:0] prbs_amplitude_config_reg;
    logic [15:0] prbs_dc_offset_config_reg;
    logic        busy;
    logic        commit_done;
    logic        cfg_err;
    logic        timeout_err;

    prbs_config_sequencer #(
        .DRAIN_CYCLES   (D),
        .TIMEOUT_CYCLES (T),
        .PN_COUNT       (PN)
    ) dut (
        .dac_clk                   (dac_clk),
        .reset                     (reset),
        .cfg_wr_en                 (cfg_wr_en),
        .cfg_addr                  (cfg_addr),
        .cfg_wdata                 (cfg_wdata),
        .commit_req                (commit_req),
        .prbs_valid                (prbs_valid),
        .prbs_mode_select          (prbs_mode_select),
        .prbs_pn_select_reg        (prbs_pn_select_reg),
        .prbs_bit_rate_config_reg  (prbs_bit_rate_config_reg),
        .prbs_edge_time_config_reg (prbs_edge_time_config_reg),
        .prbs_amplitude_config_reg (prbs_amplitude_config_reg),
        .prbs_dc_offset_config_reg (prbs_dc_offset_config_reg),
        .busy                      (busy),
        .commit_done               (commit_done),
        .cfg_err                   (cfg_err),
        .timeout_err               (timeout_err)
    );

    always #5 dac_clk = ~dac_clk;

    int checks = 0;
    int failures = 0;
    logic cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_sh  [0:5] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] m_act [0:4] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    logic m_mode = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
    logic m_terr = 1'b0, m_pend = 1'b0, m_seq = 1'b0;
    int   m_age = 0;  // cycles since the mute cycle of the running commit

    function automatic logic [31:0] fmask(input int a);
        case (a)
            0:       return 32'h0000_001F;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_00FF;
            3, 4:    return 32'h0000_FFFF;
            5:       return 32'h0000_0001;
            default: return 32'h0000_0000;
        endcase
    endfunction

    task automatic model_finish_ok();
        m_done = 1'b1;
        m_terr = 1'b0;
        m_seq  = 1'b0;
    endtask

    initial forever begin
        @(posedge dac_clk or posedge reset);
        if (reset) begin
            for (int i = 0; i < 6; i++) m_sh[i] = 32'd0;
            for (int i = 0; i < 5; i++) m_act[i] = 32'd0;
            m_mode = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
            m_terr = 1'b0; m_pend = 1'b0; m_seq = 1'b0; m_age = 0;
        end else begin
            m_done = 1'b0;
            m_err  = 1'b0;
            if (!m_seq) begin
                if (commit_req || m_pend) begin
                    m_seq = 1'b1; m_age = 0; m_pend = 1'b0;
                end
            end else begin
                if (commit_req) m_pend = 1'b1;
                if (m_age == 0) begin
                    m_mode = 1'b0; m_age = 1;            // end of mute
                end else if (m_age <= D) begin
                    m_age++;                              // draining
                end else if (m_age == D + 1) begin
                    for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
                    m_age++;
                end else if (m_age == D + 2) begin
                    if (m_sh[5][0]) begin
                        m_mode = 1'b1; m_age++;
                    end else begin
                        model_finish_ok();
                    end
                end else begin
                    if (prbs_valid) begin
                        model_finish_ok();
                    end else if (m_age - (D + 3) == T - 1) begin
                        m_mode = 1'b0; m_terr = 1'b1; m_seq = 1'b0;
                    end else begin
                        m_age++;
                    end
                end
            end
            // Shadow updates use the old values above, so they come last.
            if (cfg_wr_en) begin
                if (cfg_addr > 3'd5 || (cfg_addr == 3'd0 && cfg_wdata >= 32'(PN)))
                    m_err = 1'b1;
                else
                    m_sh[cfg_addr] = cfg_wdata & fmask(int'(cfg_addr));
            end
            m_busy = m_seq || m_pend;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge dac_clk);
        if (cmp_en && !reset) begin
            chk("cmp_mode",  32'(prbs_mode_select),          32'(m_mode));
            chk("cmp_pn",    32'(prbs_pn_select_reg),        m_act[0]);
            chk("cmp_rate",  prbs_bit_rate_config_reg,       m_act[1]);
            chk("cmp_edge",  32'(prbs_edge_time_config_reg), m_act[2]);
            chk("cmp_amp",   32'(prbs_amplitude_config_reg), m_act[3]);
            chk("cmp_dc",    32'(prbs_dc_offset_config_reg), m_act[4]);
            chk("cmp_busy",  32'(busy),                      32'(m_busy));
            chk("cmp_done",  32'(commit_done),               32'(m_done));
            chk("cmp_err",   32'(cfg_err),                   32'(m_err));
            chk("cmp_terr",  32'(timeout_err),               32'(m_terr));
        end
    end

    // ---------------- stimulus helpers ----------------
    int n_done, n_load, n_mode_on, n_end, done_cnt;

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cfg_wr_en = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge dac_clk);
        cfg_wr_en = 1'b0; cfg_addr = 3'd0; cfg_wdata = 32'd0;
    endtask

    task automatic pulse_commit();
        commit_req = 1'b1;
        @(negedge dac_clk);
        commit_req = 1'b0;
    endtask

    // Runs until busy drops; prbs_valid rises once mode_select has been high
    // for vdelay sampled cycles (vdelay < 0: never). n counts negedges after
    // the commit pulse.
    task automatic wait_idle(input int vdelay);
        int n = 0;
        int en_cnt = 0;
        logic [76:0] snap0 = {prbs_pn_select_reg, prbs_bit_rate_config_reg,
                              prbs_edge_time_config_reg, prbs_amplitude_config_reg,
                              prbs_dc_offset_config_reg};
        n_done = -1; n_load = -1; n_mode_on = -1; done_cnt = 0;
        while (busy && n < 3000) begin
            @(negedge dac_clk);
            n++;
            if (prbs_mode_select) en_cnt++; else en_cnt = 0;
            if (n_mode_on < 0 && prbs_mode_select) n_mode_on = n;
            if (n_load < 0 && snap0 != {prbs_pn_select_reg, prbs_bit_rate_config_reg,
                                        prbs_edge_time_config_reg, prbs_amplitude_config_reg,
                                        prbs_dc_offset_config_reg}) n_load = n;
            if (commit_done) begin
                done_cnt++;
                if (n_done < 0) n_done = n;
            end
            prbs_valid = (vdelay >= 0) && (en_cnt >= vdelay);
        end
        prbs_valid = 1'b0;
        n_end = n;
        chk("seq_returns_idle", 32'(busy), 32'd0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        reset = 1'b1;
        repeat (2) @(negedge dac_clk);
        chk("rst_mode", 32'(prbs_mode_select), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rate", prbs_bit_rate_config_reg, 32'd0);
        reset = 1'b0;
        cmp_en = 1'b1;
        @(negedge dac_clk);

        // 1: basic commit with valid three cycles after enable
        wr(3'd1, 32'h1000_0000);
        wr(3'd0, 32'd2);
        wr(3'd5, 32'd1);
        pulse_commit();
        wait_idle(3);
        chk("t1_load_latency", 32'(n_load), 32'd18);      // D+2 after pulse, D+1 after mute
        chk("t1_enable_latency", 32'(n_mode_on), 32'd19);
        chk("t1_done_latency", 32'(n_done), 32'd22);
        chk("t1_done_count", 32'(done_cnt), 32'd1);
        chk("t1_rate", prbs_bit_rate_config_reg, 32'h1000_0000);
        chk("t1_pn", 32'(prbs_pn_select_reg), 32'd2);
        chk("t1_mode", 32'(prbs_mode_select), 32'd1);

        // 2: illegal PN select is rejected
        wr(3'd0, 32'd9);
        chk("t2_cfg_err_pulse", 32'(cfg_err), 32'd1);
        wr(3'd7, 32'h0000_0001);
        chk("t2_cfg_err_addr7", 32'(cfg_err), 32'd1);
        wr(3'd4, 32'h0001_ABCD);                           // truncated to 16 bits
        chk("t2_cfg_err_clear", 32'(cfg_err), 32'd0);
        pulse_commit();
        wait_idle(1);
        chk("t2_pn_kept", 32'(prbs_pn_select_reg), 32'd2);
        chk("t2_dc_trunc", 32'(prbs_dc_offset_config_reg), 32'h0000_ABCD);

        // 3: timeout, then recovery clears the sticky flag
        pulse_commit();
        wait_idle(-1);
        chk("t3_timeout_err", 32'(timeout_err), 32'd1);
        chk("t3_mode_off", 32'(prbs_mode_select), 32'd0);
        chk("t3_no_done", 32'(done_cnt), 32'd0);
        chk("t3_timeout_latency", 32'(n_end), 32'(D + 3 + T));
        pulse_commit();
        wait_idle(2);
        chk("t3_terr_cleared", 32'(timeout_err), 32'd0);

        // 4: two requests during drain merge into exactly one rerun
        wr(3'd3, 32'h0000_1111);
        pulse_commit();
        repeat (3) @(negedge dac_clk);
        pulse_commit();
        wr(3'd3, 32'h0000_4000);
        pulse_commit();
        wait_idle(1);
        chk("t4_done_count", 32'(done_cnt), 32'd2);
        chk("t4_amp", 32'(prbs_amplitude_config_reg), 32'h0000_4000);

        // 5: commit with enable = 0 leaves generator muted
        wr(3'd5, 32'd0);
        wr(3'd2, 32'h0000_015A);                           // truncated to 8 bits
        pulse_commit();
        wait_idle(-1);
        chk("t5_edge", 32'(prbs_edge_time_config_reg), 32'h0000_005A);
        chk("t5_mode_off", 32'(prbs_mode_select), 32'd0);
        chk("t5_never_enabled", 32'(n_mode_on), 32'hFFFF_FFFF);
        chk("t5_done_latency", 32'(n_done), 32'd19);
        chk("t5_terr", 32'(timeout_err), 32'd0);

        // 6: reset during WAIT_VALID, with a pending request, is immediate
        wr(3'd5, 32'd1);
        pulse_commit();
        for (int i = 0; i < 100 && !prbs_mode_select; i++) @(negedge dac_clk);
        chk("t6_reached_wait", 32'(prbs_mode_select), 32'd1);
        repeat (3) @(negedge dac_clk);
        pulse_commit();
        #2 reset = 1'b1;
        #1;
        chk("t6_async_mode", 32'(prbs_mode_select), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        chk("t6_async_rate", prbs_bit_rate_config_reg, 32'd0);
        chk("t6_async_amp", 32'(prbs_amplitude_config_reg), 32'd0);
        @(negedge dac_clk);
        reset = 1'b0;
        repeat (40) @(negedge dac_clk);
        chk("t6_no_rerun_busy", 32'(busy), 32'd0);
        chk("t6_no_rerun_mode", 32'(prbs_mode_select), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prbs_config_sequencer.md
Name: prbs_config_sequencer

Overview:
Host-side controller for the PRBS generator datapath in the dac_clk domain. It holds shadow copies of every PRBS configuration field and applies them atomically through a glitch-free commit sequence: mute, drain, load, re-enable, then confirm valid output. This prevents the DAC from seeing half-updated pattern, rate or amplitude settings. A status/timeout path reports when the generator fails to come back up.

Parameters:
DRAIN_CYCLES, 16, cycles mode_select is held low before new config is loaded (1..255)
TIMEOUT_CYCLES, 1024, max cycles to wait for prbs_valid after re-enable
PN_COUNT, 8, number of supported PN selections; legal pn_select is 0..PN_COUNT-1

Ports:
dac_clk  in  1  DAC-domain clock
reset  in  1  asynchronous reset, active-high
cfg_wr_en  in  1  single-cycle shadow register write strobe
cfg_addr  in  3  shadow select: 0 pn_select, 1 bit_rate, 2 edge_time, 3 amplitude, 4 dc_offset, 5 enable (bit0)
cfg_wdata  in  32  write data, LSB-aligned and truncated to field width
commit_req  in  1  single-cycle request to apply shadow registers
prbs_valid  in  1  valid flag from the PRBS generator
prbs_mode_select  out  1  generator enable
prbs_pn_select_reg  out  5  active PN selection
prbs_bit_rate_config_reg  out  32  active phase increment
prbs_edge_time_config_reg  out  8  active edge time
prbs_amplitude_config_reg  out  16  active amplitude
prbs_dc_offset_config_reg  out  16  active DC offset
busy  out  1  high whenever state != IDLE
commit_done  out  1  one-cycle pulse on successful commit
cfg_err  out  1  one-cycle pulse on an illegal write
timeout_err  out  1  sticky; cleared only by reset or the next successful commit

Behaviour:
- Reset (async, immediate): all outputs 0; all shadows 0; state IDLE; pending cleared; counters 0.
- Shadow writes:
  - Accepted in any state; a write lands in the shadow on the cycle after the cfg_wr_en edge.
  - Active outputs change only in LOAD.
  - addr 6/7, or addr 0 with data >= PN_COUNT: shadow is unchanged and cfg_err pulses on the next cycle.
- FSM states: IDLE, MUTE, DRAIN, LOAD, ENABLE, WAIT_VALID.
- IDLE: commit_req or pending set -> MUTE; pending cleared.
- MUTE (1 cycle): prbs_mode_select <= 0; drain counter <= 0 -> DRAIN.
- DRAIN: counter increments each cycle; leaves at count DRAIN_CYCLES-1 -> LOAD. Mute-to-load is exactly DRAIN_CYCLES+1 cycles.
- LOAD (1 cycle): all five active config outputs copy their shadows simultaneously. Writes arriving in this same cycle are not included and stay in the shadow. -> ENABLE.
- ENABLE:
  - shadow enable = 1: prbs_mode_select <= 1; timeout counter <= 0 -> WAIT_VALID.
  - shadow enable = 0: commit_done pulses; timeout_err cleared -> IDLE (generator left muted).
- WAIT_VALID:
  - prbs_valid = 1: commit_done pulses; timeout_err cleared -> IDLE.
  - counter reaches TIMEOUT_CYCLES-1 with prbs_valid still 0: prbs_mode_select <= 0; timeout_err <= 1 -> IDLE.
  - prbs_valid and timeout in the same cycle: valid wins.
- commit_req while busy: sets a 1-deep pending flag; extra requests merge. When the FSM reaches IDLE with pending set, MUTE starts on the following cycle, with busy held high through the IDLE cycle.
- commit_req in IDLE together with cfg_wr_en: the write still lands before LOAD, so it is included.
- Counter widths: drain counter 8 bits; timeout counter clog2(TIMEOUT_CYCLES) bits. Neither counter wraps; both are reset on state entry.
- Reset asserted mid-sequence: immediate return to IDLE with all outputs at 0; a pending commit is discarded.

Test Plan:
- Reset then idle: all outputs 0, busy 0. Write addr1 = 0x10000000, addr0 = 2, addr5 = 1, then commit_req -> mode_select falls 1 cycle later. Outputs update exactly DRAIN_CYCLES+1 cycles after the fall. Model prbs_valid high 3 cycles after enable -> commit_done pulses once, busy drops.
- Write addr0 = 9 (PN_COUNT = 8) -> cfg_err pulse; after a commit, prbs_pn_select_reg keeps its prior value.
- Hold prbs_valid = 0 after enable -> timeout_err = 1 and mode_select = 0 after TIMEOUT_CYCLES. A later successful commit clears timeout_err.
- Two commit_req pulses during DRAIN, with a write of amplitude 0x4000 between them -> exactly one extra sequence runs; the second commit applies amplitude 0x4000.
- Commit with enable = 0 -> config outputs load, mode_select stays 0, commit_done pulses with no wait on prbs_valid.
- Assert reset during WAIT_VALID -> all outputs 0 asynchronously; after release, no sequence runs without a new commit_req.
